// File: rtl/aes_pkg.sv
// Shared AES definitions: block width, iterative-FSM state encoding and the
// FIPS-197 forward S-box as a pure lookup function.
package aes_pkg;

   localparam int AES_BLOCK_W = 128;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } stateT;

   // Entry for input byte x sits at bits [2047-8x -: 8] (row-major, 0x00 first).
   localparam logic [2047:0] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sboxFwd(input logic [7:0] b);
      return SBOX_TABLE[2047 - 8*int'(b) -: 8];
   endfunction

endpackage

// File: rtl/sbox_fwd.sv
// Combinational forward AES S-box for one byte.
//   byteIn  : input byte
//   byteOut : S-box image of byteIn
module sbox_fwd
   import aes_pkg::*;
(
   input  logic [7:0] byteIn,
   output logic [7:0] byteOut
);

   assign byteOut = sboxFwd(byteIn);

endmodule

// File: rtl/sub_bytes_iter.sv
// Iterative AES SubBytes: substitutes BPC bytes per cycle, most-significant
// chunk first, over NCYC = 16/BPC cycles.
//
// state | meaning
// IDLE  | waiting for in_valid; in_ready=1
// BUSY  | substituting one chunk per cycle
// DONE  | result held on out_data with out_valid=1 until out_ready
//
// Ports:
//   clk, rst           : clock, async active-high reset
//   in_valid/in_ready  : input handshake, in_data = 128-bit AES state
//   out_valid/out_ready: output handshake, out_data = substituted state
//   busy               : high in BUSY and DONE
module sub_bytes_iter
   import aes_pkg::*;
#(
   parameter int BPC = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [AES_BLOCK_W-1:0] in_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [AES_BLOCK_W-1:0] out_data,
   output logic                   busy
);

   localparam int NCYC = 16 / BPC;
   localparam int CHW  = 8 * BPC;
   localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;

   if (!(BPC == 1 || BPC == 2 || BPC == 4 || BPC == 8 || BPC == 16)) begin : gBadBpc
      $error("sub_bytes_iter: BPC must be 1, 2, 4, 8 or 16");
   end

   stateT                  state;
   stateT                  stateNext;
   logic [CW-1:0]          chunkCnt;
   logic [AES_BLOCK_W-1:0] workReg;
   logic [6:0]             chunkTop;
   logic [CHW-1:0]         chunkIn;
   logic [CHW-1:0]         chunkOut;
   logic                   lastChunk;

   // Chunk 0 is the top of the block; each count steps CHW bits toward bit 0.
   assign chunkTop  = 7'(AES_BLOCK_W - 1 - CHW * int'(chunkCnt));
   assign chunkIn   = workReg[chunkTop -: CHW];
   assign lastChunk = (chunkCnt == CW'(NCYC - 1));

   for (genvar g = 0; g < BPC; g++) begin : gSbox
      sbox_fwd uSbox (
         .byteIn  (chunkIn[8*g +: 8]),
         .byteOut (chunkOut[8*g +: 8])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         chunkCnt <= '0;
         workReg  <= '0;
      end else begin
         state <= stateNext;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  workReg  <= in_data;
                  chunkCnt <= '0;
               end
            end
            BUSY: begin
               workReg[chunkTop -: CHW] <= chunkOut;
               chunkCnt <= lastChunk ? '0 : chunkCnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (in_valid)  stateNext = BUSY;
         BUSY:    if (lastChunk) stateNext = DONE;
         DONE:    if (out_ready) stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
      busy      = (state != IDLE);
   end

   // Intermediate (partially substituted) values are deliberately visible.
   assign out_data = workReg;

endmodule
